// File: rtl/pipe_ctrl_stage.sv
// Elastic valid/ready boundary register for a control bundle plus a data bundle.
// It holds up to two entries (SKID=1) or one (SKID=0) and shows an all-zero control bubble when empty.
module pipe_ctrl_stage #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 96,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;

    logic do_accept;
    logic do_release;

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = {state_q == ST_FULL, state_q == ST_ONE};
    assign out_data  = main_data_q;
    // Bubble: the downstream never sees write/read enables from an empty stage.
    assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state_q != ST_FULL);
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign do_accept  = in_valid && in_ready;
    assign do_release = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        // Flush drops only the valid state; payload registers keep their contents.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (do_accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (do_accept && do_release) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (do_accept) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (do_release) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (do_release) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Bench for pipe_ctrl_stage: drives a SKID=1 and a SKID=0 instance from the same inputs
// and compares both against a FIFO-queue reference, plus a table of hand-computed vectors.
module tb_pipe_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [4:0]  in_ctrl;
    logic [95:0] in_data;

    logic        ir_s, ov_s, ir_n, ov_n;
    logic [4:0]  oc_s, oc_n;
    logic [95:0] od_s, od_n;
    logic [1:0]  occ_s, occ_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  c;
        logic [95:0] d;
    } ent_t;

    ent_t q_s[$];
    ent_t q_n[$];

    typedef struct {
        bit          f;
        bit          v;
        bit          r;
        logic [4:0]  c;
        logic [95:0] d;
        bit          ev;
        logic [4:0]  ec;
        logic [95:0] ed;
        logic [1:0]  eo;
        bit          eir;
    } vec_t;

    vec_t vt[13];

    always #5 clk = ~clk;

    pipe_ctrl_stage #(.CTRL_W(5), .DATA_W(96), .SKID(1)) dut_s (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_s), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov_s), .out_ready(out_ready), .out_ctrl(oc_s), .out_data(od_s),
        .occupancy(occ_s)
    );

    pipe_ctrl_stage #(.CTRL_W(5), .DATA_W(96), .SKID(0)) dut_n (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_n), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov_n), .out_ready(out_ready), .out_ctrl(oc_n), .out_data(od_n),
        .occupancy(occ_n)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected outputs follow directly from the queue contents: head, size, capacity.
    task automatic check_model();
        logic [4:0] ec;
        ec = (q_s.size() > 0) ? q_s[0].c : 5'd0;
        chk("s_in_ready", 128'(ir_s), 128'(q_s.size() < 2));
        chk("s_out_valid", 128'(ov_s), 128'(q_s.size() > 0));
        chk("s_out_ctrl", 128'(oc_s), 128'(ec));
        chk("s_occupancy", 128'(occ_s), 128'(q_s.size()));
        if (q_s.size() > 0) chk("s_out_data", 128'(od_s), 128'(q_s[0].d));
        ec = (q_n.size() > 0) ? q_n[0].c : 5'd0;
        chk("n_in_ready", 128'(ir_n), 128'(q_n.size() == 0 || out_ready));
        chk("n_out_valid", 128'(ov_n), 128'(q_n.size() > 0));
        chk("n_out_ctrl", 128'(oc_n), 128'(ec));
        chk("n_occupancy", 128'(occ_n), 128'(q_n.size()));
        if (q_n.size() > 0) chk("n_out_data", 128'(od_n), 128'(q_n[0].d));
    endtask

    // One clock: check at negedge, then advance the reference queues past the posedge.
    task automatic cycle();
        bit   f, acc_s, rel_s, acc_n, rel_n;
        ent_t e;
        @(negedge clk);
        check_model();
        f     = flush;
        e.c   = in_ctrl;
        e.d   = in_data;
        rel_s = (q_s.size() > 0) && out_ready;
        acc_s = in_valid && (q_s.size() < 2);
        rel_n = (q_n.size() > 0) && out_ready;
        acc_n = in_valid && (q_n.size() == 0 || out_ready);
        @(posedge clk);
        #1;
        if (f) begin
            q_s.delete();
            q_n.delete();
        end else begin
            if (rel_s) void'(q_s.pop_front());
            if (acc_s) q_s.push_back(e);
            if (rel_n) void'(q_n.pop_front());
            if (acc_n) q_n.push_back(e);
        end
    endtask

    initial begin
        // f, v, r, ctrl, data  ->  valid, ctrl, data, occupancy, in_ready (SKID=1, after the edge)
        vt[0]  = '{1'b0, 1'b1, 1'b0, 5'h0A, 96'd100, 1'b1, 5'h0A, 96'd100, 2'd1, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 5'h0B, 96'd101, 1'b1, 5'h0A, 96'd100, 2'd2, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 5'h0C, 96'd102, 1'b1, 5'h0A, 96'd100, 2'd2, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 5'h0C, 96'd102, 1'b1, 5'h0B, 96'd101, 2'd1, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 5'h0C, 96'd102, 1'b1, 5'h0C, 96'd102, 2'd1, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 5'h0D, 96'd103, 1'b0, 5'h00, 96'd0,   2'd0, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 5'h1F, 96'd200, 1'b1, 5'h1F, 96'd200, 2'd1, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 5'h11, 96'd201, 1'b1, 5'h1F, 96'd200, 2'd2, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 5'h12, 96'd202, 1'b0, 5'h00, 96'd0,   2'd0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 5'h13, 96'hFFFF, 1'b0, 5'h00, 96'd0,  2'd0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 5'h14, 96'h0, 1'b0, 5'h00, 96'd0,     2'd0, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b1, 5'h15, 96'd300, 1'b1, 5'h15, 96'd300, 2'd1, 1'b1};
        vt[12] = '{1'b1, 1'b1, 1'b0, 5'h16, 96'd301, 1'b0, 5'h00, 96'd0,   2'd0, 1'b1};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 128'(ov_s), 128'(0));
        chk("reset_out_ctrl", 128'(oc_s), 128'(0));
        chk("reset_out_data", 128'(od_s), 128'(0));
        chk("reset_occupancy", 128'(occ_s), 128'(0));
        chk("reset_in_ready", 128'(ir_s), 128'(1));
        chk("reset_n_in_ready", 128'(ir_n), 128'(1));
        rst = 1'b0;

        // Reset in the middle of a transfer with entries held.
        in_valid = 1'b1;
        in_ctrl  = 5'h1F;
        in_data  = 96'd55;
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(ov_s), 128'(0));
        chk("midrst_out_ctrl", 128'(oc_s), 128'(0));
        chk("midrst_occupancy", 128'(occ_s), 128'(0));
        chk("midrst_in_ready", 128'(ir_s), 128'(1));
        chk("midrst_n_out_valid", 128'(ov_n), 128'(0));
        q_s.delete();
        q_n.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 5'h0A;
        in_data  = 96'd77;
        cycle();
        in_valid = 1'b0;
        chk("post_rst_valid", 128'(ov_s), 128'(1));
        chk("post_rst_ctrl", 128'(oc_s), 128'(5'h0A));
        chk("post_rst_data", 128'(od_s), 128'(77));
        out_ready = 1'b1;
        repeat (2) cycle();

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 5'(i);
            in_data  = 96'(i);
            cycle();
            chk("stream_data", 128'(od_s), 128'(i));
            chk("stream_occ", 128'(occ_s), 128'(1));
        end
        in_valid = 1'b0;
        cycle();

        // Backpressure, flush and bubble vectors.
        for (int i = 0; i < 13; i++) begin
            flush     = vt[i].f;
            in_valid  = vt[i].v;
            out_ready = vt[i].r;
            in_ctrl   = vt[i].c;
            in_data   = vt[i].d;
            cycle();
            chk($sformatf("vec%0d_valid", i), 128'(ov_s), 128'(vt[i].ev));
            chk($sformatf("vec%0d_ctrl", i), 128'(oc_s), 128'(vt[i].ec));
            chk($sformatf("vec%0d_occ", i), 128'(occ_s), 128'(vt[i].eo));
            chk($sformatf("vec%0d_in_ready", i), 128'(ir_s), 128'(vt[i].eir));
            if (vt[i].ev) chk($sformatf("vec%0d_data", i), 128'(od_s), 128'(vt[i].ed));
        end
        flush = 1'b0;

        // SKID=0 with toggling out_ready and continuous input.
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            out_ready = (i % 2 == 0);
            in_ctrl   = 5'(i + 3);
            in_data   = 96'(1000 + i);
            cycle();
            chk("n_occ_max", 128'(occ_n <= 2'd1), 128'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        // Randomised traffic against the queue reference.
        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_ctrl   = 5'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            cycle();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_stage.md
# pipe_ctrl_stage

Parametrised elastic pipeline boundary register for the 3-stage core, carrying a control bundle and a data bundle across a stage boundary under a valid/ready handshake. Generalises the plain enable-held control buffer with configurable field widths, an optional 2-entry skid buffer, synchronous flush and automatic bubble (all-zero control) insertion when the stage is empty. Sits between Execute and Memory/Writeback. The same block serves the control bundle (reg_wr, wr_en, rd_en, wb_sel) and the datapath bundle (PC, ALU result, rs2 data, rd).

## Interface
- CTRL_W, default 5: control bundle width. Bubble value is all-zero.
- DATA_W, default 96: data bundle width.
- SKID, default 1: 1 gives a 2-entry buffer with registered in_ready. 0 gives a single entry with combinational in_ready.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head this cycle.
- out_ctrl  out  CTRL_W  head control. Forced to 0 when out_valid=0.
- out_data  out  DATA_W  head data. Don't-care when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).

## Operation
- Accept: in_valid & in_ready at a rising edge.
- Release: out_valid & out_ready at a rising edge.
- Entries leave in arrival order. No entry is duplicated or lost except by flush.
- State machine (SKID=1), with main = head register and skid = second register:
  - EMPTY (occ 0):
    - accept → ONE, main<=in.
  - ONE (occ 1):
    - accept & release → ONE, main<=in.
    - accept & !release → FULL, skid<=in.
    - release & !accept → EMPTY.
    - otherwise hold.
  - FULL (occ 2): in_ready=0.
    - release → ONE, main<=skid.
    - otherwise hold.
- SKID=0:
  - in_ready = !out_valid | out_ready.
  - accept loads main.
  - release without accept → EMPTY.
- Flush has highest priority below rst:
  - Next state is EMPTY regardless of in_valid or out_ready.
  - An input presented in the flush cycle is discarded.
  - The head shown during the flush cycle counts as not released, even if out_ready=1. Downstream must qualify its own commit with !flush.
- Bubble rule:
  - out_ctrl = main_ctrl when out_valid, else 0.
  - Downstream therefore never sees reg_wr/wr_en/rd_en asserted for an empty stage.
- Hold: with no accept and no release, all registers keep their values. This replaces the old en=0 stall.
- Data registers are not cleared on flush or release. Only the valid state is cleared.

## Timing
- Reset values (asynchronous, immediate on rst rise):
  - State EMPTY.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - Internal main/skid=0.
  - in_ready=1.
- Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N (cycle N+1). There is no combinational in→out path.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- SKID=1:
  - in_ready is a pure register decode (state != FULL) with no dependency on out_ready.
  - in_ready drops the cycle after the 2nd entry is stored.
  - in_ready rises the cycle after the FULL→ONE release.
- SKID=0: in_ready depends combinationally on out_ready.
- out_valid, out_ctrl, out_data and occupancy are register-driven. The out_ctrl mask is a single AND with out_valid.
- Reset mid-transfer: all entries are dropped. The first accept after rst deassertion behaves as from EMPTY.
- Flush and accept at the same edge: the result is EMPTY, and in_ready=1 the next cycle.

## Test plan
- Reset:
  - Stimulus: rst pulse mid-cycle with in_valid=1, in_ctrl=5'h1F.
  - Required: out_valid=0, out_ctrl=0, occupancy=0 immediately; in_ready=1.
  - Required: after release, accept of ctrl=5'h0A appears at out one cycle later.
- Streaming:
  - Stimulus: out_ready=1; 8 back-to-back entries with data=0..7 and ctrl=i[4:0].
  - Required: out_valid high from cycle 1; data 0..7 in order, one per cycle; occupancy stays 1.
- Backpressure (SKID=1):
  - Stimulus: out_ready=0; push A, B, C.
  - Required: A and B accepted; occupancy=2; in_ready=0 the cycle after B; C is held upstream.
  - Stimulus: then raise out_ready.
  - Required: outputs A, B, C in order; no loss.
- Flush:
  - Stimulus: FULL with ctrl=5'h1F at head; assert flush with in_valid=1.
  - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed input never appears.
- Bubble:
  - Stimulus: drain to EMPTY while in_data toggles.
  - Required: out_ctrl=0 every empty cycle, including reg_wr=0 and wr_en=0.
- SKID=0 variant:
  - Stimulus: out_ready toggling 1,0,1,0 with continuous in_valid.
  - Required: in_ready tracks out_ready combinationally when full; occupancy never exceeds 1; order preserved.
